// File: rtl/fsa_tsi_pkg.sv
// Shared constants and the FSM state type for the chip-side TSI responder.
package fsa_tsi_pkg;

  localparam int TSI_W = 32;
  localparam logic [TSI_W-1:0] CMD_READ  = 32'd0;
  localparam logic [TSI_W-1:0] CMD_WRITE = 32'd1;
  localparam int ADDR_INC = 4;

  typedef enum logic [3:0] {
    S_CMD,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_WDATA,
    S_WREQ,
    S_WRESP,
    S_RREQ,
    S_RRESP,
    S_RDATA
  } tsi_state_e;

endpackage

// File: rtl/fsa_tsi_target.sv
// Chip-side TSI target: decodes host read/write commands into single-word
// memory requests and streams read data back to the host.
module fsa_tsi_target
  import fsa_tsi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tsi_in_valid,
  output logic              tsi_in_ready,
  input  logic [TSI_W-1:0]  tsi_in_bits,
  output logic              tsi_out_valid,
  input  logic              tsi_out_ready,
  output logic [TSI_W-1:0]  tsi_out_bits,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [TSI_W-1:0]  mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [TSI_W-1:0]  mem_resp_rdata,
  output logic              busy,
  output logic              cmd_err
);

  tsi_state_e        state;
  tsi_state_e        state_next;
  logic              in_en;
  logic              is_write;
  logic              in_fire;
  logic              cmd_legal;
  logic [ADDR_W-1:0] addr;
  logic [TSI_W-1:0]  addr_lo;
  logic [TSI_W-1:0]  cnt;
  logic [TSI_W-1:0]  wdata;
  logic [TSI_W-1:0]  rdata;

  assign in_fire   = tsi_in_valid && tsi_in_ready;
  assign cmd_legal = (tsi_in_bits == CMD_READ) || (tsi_in_bits == CMD_WRITE);

  // in_en keeps tsi_in_ready low during reset and for the first cycle after it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_CMD;
      in_en <= 1'b0;
    end else begin
      state <= state_next;
      in_en <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_CMD:     if (in_fire && cmd_legal) state_next = S_ADDR_LO;
      S_ADDR_LO: if (in_fire) state_next = S_ADDR_HI;
      S_ADDR_HI: if (in_fire) state_next = S_LEN_LO;
      S_LEN_LO:  if (in_fire) state_next = S_LEN_HI;
      S_LEN_HI:  if (in_fire) state_next = is_write ? S_WDATA : S_RREQ;
      S_WDATA:   if (in_fire) state_next = S_WREQ;
      S_WREQ:    if (mem_req_ready) state_next = S_WRESP;
      S_WRESP:   if (mem_resp_valid) state_next = (cnt == '0) ? S_CMD : S_WDATA;
      S_RREQ:    if (mem_req_ready) state_next = S_RRESP;
      S_RRESP:   if (mem_resp_valid) state_next = S_RDATA;
      S_RDATA:   if (tsi_out_ready) state_next = (cnt == '0) ? S_CMD : S_RREQ;
      default:   state_next = S_CMD;
    endcase
  end

  // Datapath registers; the address is truncated to ADDR_W and word-aligned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_write <= 1'b0;
      addr     <= '0;
      addr_lo  <= '0;
      cnt      <= '0;
      wdata    <= '0;
      rdata    <= '0;
      cmd_err  <= 1'b0;
    end else begin
      unique case (state)
        S_CMD: begin
          if (in_fire) begin
            if (tsi_in_bits == CMD_WRITE) is_write <= 1'b1;
            else if (tsi_in_bits == CMD_READ) is_write <= 1'b0;
            else cmd_err <= 1'b1;
          end
        end
        S_ADDR_LO: if (in_fire) addr_lo <= tsi_in_bits;
        S_ADDR_HI: if (in_fire) addr <= ADDR_W'({tsi_in_bits, addr_lo} & ~64'd3);
        S_LEN_LO:  if (in_fire) cnt <= tsi_in_bits;
        S_WDATA:   if (in_fire) wdata <= tsi_in_bits;
        S_WRESP: begin
          if (mem_resp_valid) begin
            addr <= addr + ADDR_W'(ADDR_INC);
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        S_RRESP:   if (mem_resp_valid) rdata <= mem_resp_rdata;
        S_RDATA: begin
          if (tsi_out_ready) begin
            addr <= addr + ADDR_W'(ADDR_INC);
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tsi_in_ready  = in_en && (state inside {S_CMD, S_ADDR_LO, S_ADDR_HI,
                                                  S_LEN_LO, S_LEN_HI, S_WDATA});
  assign tsi_out_valid = (state == S_RDATA);
  assign tsi_out_bits  = rdata;
  assign mem_req_valid = (state == S_WREQ) || (state == S_RREQ);
  assign mem_req_write = (state == S_WREQ);
  assign mem_req_addr  = addr;
  assign mem_req_wdata = wdata;
  assign busy          = (state != S_CMD);

endmodule

// File: tb/tb_fsa_tsi_target.sv
// Directed self-checking bench for fsa_tsi_target: writes, reads, stalls,
// illegal commands, address wrap and reset in the middle of a command.
module tb_fsa_tsi_target;
  import fsa_tsi_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tsi_in_valid = 1'b0;
  logic        tsi_in_ready;
  logic [31:0] tsi_in_bits = '0;
  logic        tsi_out_valid;
  logic        tsi_out_ready = 1'b0;
  logic [31:0] tsi_out_bits;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        busy;
  logic        cmd_err;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  fsa_tsi_target #(.ADDR_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .tsi_in_valid(tsi_in_valid),
    .tsi_in_ready(tsi_in_ready),
    .tsi_in_bits(tsi_in_bits),
    .tsi_out_valid(tsi_out_valid),
    .tsi_out_ready(tsi_out_ready),
    .tsi_out_bits(tsi_out_bits),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, output logic ok);
    int n = 0;
    tsi_in_valid = 1'b1;
    tsi_in_bits  = w;
    while (!tsi_in_ready && n < 50) begin
      tick();
      n++;
    end
    ok = tsi_in_ready;
    if (ok) tick();
    tsi_in_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] cmd, input logic [31:0] lo,
                             input logic [31:0] hi, input logic [31:0] len,
                             output logic ok);
    logic o;
    ok = 1'b1;
    send_word(cmd, o);  ok &= o;
    send_word(lo, o);   ok &= o;
    send_word(hi, o);   ok &= o;
    send_word(len, o);  ok &= o;
    send_word(32'h0, o); ok &= o;
  endtask

  task automatic mem_accept(output logic ok, output logic wr,
                            output logic [31:0] a, output logic [31:0] d);
    int n = 0;
    while (!mem_req_valid && n < 50) begin
      tick();
      n++;
    end
    ok = mem_req_valid;
    wr = mem_req_write;
    a  = mem_req_addr;
    d  = mem_req_wdata;
    if (ok) begin
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
    end
  endtask

  task automatic mem_respond(input logic [31:0] rd);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rd;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic host_take(input int stall, output logic ok,
                           output logic [31:0] bits, output logic stable);
    int n = 0;
    stable = 1'b1;
    while (!tsi_out_valid && n < 50) begin
      tick();
      n++;
    end
    ok   = tsi_out_valid;
    bits = tsi_out_bits;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (tsi_out_bits !== bits || tsi_out_valid !== 1'b1 || mem_req_valid !== 1'b0)
        stable = 1'b0;
    end
    tsi_out_ready = 1'b1;
    tick();
    tsi_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({tsi_in_ready, tsi_out_valid, mem_req_valid, mem_req_write, busy, cmd_err} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b want 000000",
               {tsi_in_ready, tsi_out_valid, mem_req_valid, mem_req_write, busy, cmd_err});
    end
    total++;
    if ({mem_req_addr, mem_req_wdata, tsi_out_bits} !== 96'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: addr=%h wdata=%h out=%h want 0",
               mem_req_addr, mem_req_wdata, tsi_out_bits);
    end
    reset = 1'b1;
    tick();
    total++;
    if (tsi_in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_ready: ready=%b busy=%b want 1/0", tsi_in_ready, busy);
    end
  endtask

  task automatic test_write();
    logic ok, wr;
    logic [31:0] a, d;
    logic [31:0] exp_addr [2] = '{32'h8000_0000, 32'h8000_0004};
    logic [31:0] exp_data [2] = '{32'hDEAD_BEEF, 32'h1234_5678};
    send_header(CMD_WRITE, 32'h8000_0000, 32'h0, 32'd1, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wr_header: accepted=%b want 1", ok);
    end
    for (int i = 0; i < 2; i++) begin
      send_word(exp_data[i], ok);
      total++;
      if (ok !== 1'b1) begin
        bad++;
        $display("[TB] FAIL wr_data_accept[%0d]: accepted=%b want 1", i, ok);
      end
      mem_accept(ok, wr, a, d);
      total++;
      if ({ok, wr, a, d} !== {2'b11, exp_addr[i], exp_data[i]}) begin
        bad++;
        $display("[TB] FAIL wr_req[%0d]: ok=%b wr=%b addr=%h data=%h want 1 1 %h %h",
                 i, ok, wr, a, d, exp_addr[i], exp_data[i]);
      end
      total++;
      if (tsi_out_valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL wr_wait[%0d]: out_valid=%b busy=%b want 0/1", i, tsi_out_valid, busy);
      end
      mem_respond(32'h0);
    end
    total++;
    if (busy !== 1'b0 || tsi_out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wr_done: busy=%b out_valid=%b want 0/0", busy, tsi_out_valid);
    end
  endtask

  task automatic test_read(input string name, input logic [31:0] lo, input logic [31:0] hi,
                           input logic [31:0] len, input logic [31:0] data_base,
                           input int stall);
    logic ok, wr, stable;
    logic [31:0] a, d, bits, exp_addr;
    exp_addr = {lo[31:2], 2'b00};
    send_header(CMD_READ, lo, hi, len, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_header: accepted=%b want 1", name, ok);
    end
    for (int i = 0; i <= int'(len); i++) begin
      mem_accept(ok, wr, a, d);
      total++;
      if ({ok, wr, a} !== {2'b10, exp_addr}) begin
        bad++;
        $display("[TB] FAIL %s_req[%0d]: ok=%b wr=%b addr=%h want 1 0 %h",
                 name, i, ok, wr, a, exp_addr);
      end
      mem_respond(data_base + 32'(i));
      total++;
      if (tsi_out_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL %s_latency[%0d]: out_valid=%b want 1", name, i, tsi_out_valid);
      end
      host_take(stall, ok, bits, stable);
      total++;
      if ({ok, stable, bits} !== {2'b11, data_base + 32'(i)}) begin
        bad++;
        $display("[TB] FAIL %s_data[%0d]: ok=%b stable=%b bits=%h want 1 1 %h",
                 name, i, ok, stable, bits, data_base + 32'(i));
      end
      exp_addr = exp_addr + 32'd4;
    end
    total++;
    if (busy !== 1'b0 || tsi_out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_done: busy=%b out_valid=%b req=%b want 0/0/0",
               name, busy, tsi_out_valid, mem_req_valid);
    end
  endtask

  task automatic test_illegal_cmd();
    logic ok;
    send_word(32'h7, ok);
    total++;
    if ({ok, cmd_err, busy} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL illegal_cmd: accepted=%b cmd_err=%b busy=%b want 1 1 0", ok, cmd_err, busy);
    end
    test_read("after_illegal", 32'h20, 32'h0, 32'd0, 32'h0000_00C0, 0);
    total++;
    if (cmd_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL cmd_err_sticky: cmd_err=%b want 1", cmd_err);
    end
  endtask

  task automatic test_reset_mid_cmd();
    logic ok;
    send_header(CMD_WRITE, 32'h40, 32'h0, 32'd0, ok);
    send_word(32'h5555_AAAA, ok);
    total++;
    if ({ok, mem_req_valid, mem_req_write} !== 3'b111) begin
      bad++;
      $display("[TB] FAIL mid_setup: accepted=%b req=%b write=%b want 1 1 1",
               ok, mem_req_valid, mem_req_write);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({tsi_in_ready, tsi_out_valid, mem_req_valid, mem_req_write, busy, cmd_err} !== 6'b0 ||
        mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL mid_reset: flags=%b addr=%h wdata=%h want 000000 0 0",
               {tsi_in_ready, tsi_out_valid, mem_req_valid, mem_req_write, busy, cmd_err},
               mem_req_addr, mem_req_wdata);
    end
    tick();
    reset = 1'b1;
    tick();
    test_read("post_reset", 32'h300, 32'h0, 32'd0, 32'h0000_00D0, 0);
  endtask

  initial begin
    $display("[TB] start");
    tick();
    tick();
    test_reset();
    test_write();
    test_read("read", 32'h1000, 32'h0, 32'd2, 32'h0000_00A0, 0);
    test_read("stall", 32'h1003, 32'h0000_ABCD, 32'd2, 32'h0000_00A0, 5);
    test_illegal_cmd();
    test_read("wrap", 32'hFFFF_FFFC, 32'h0, 32'd1, 32'h0000_00B0, 0);
    test_reset_mid_cmd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
